// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: flag bit positions, the flag
// vector type, the stored result entry and the output-stage state encoding.
package alu_pkg;

    // Default datapath width of the adder and its result stage.
    localparam int ALU_WIDTH = 32;

    // Bit positions inside a flags_t vector, ordered {N,Z,C,V}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

    // One adder result as held by the output stage: sum plus its status flags.
    typedef struct packed {
        logic [ALU_WIDTH-1:0] sum;
        flags_t               flags;
    } entry_t;

    // Occupancy of the output stage (number of valid entries held).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Assemble a flag vector from individual status bits.
    function automatic flags_t pack_flags(input logic n, input logic z,
                                          input logic c, input logic v);
        flags_t f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V generation for an adder result. Signed overflow is
// detected from the operand and sum sign bits, so it needs x and y as well
// as the sum.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] s,
    input  logic             c_out,
    output flags_t           flags
);

    logic n_s;
    logic z_s;
    logic v_s;

    // Derive the individual status bits from the sign bits and the sum.
    always_comb begin
        n_s = s[WIDTH-1];
        z_s = (s == {WIDTH{1'b0}});
        // Overflow: both operands share a sign that the sum does not carry.
        if (x[WIDTH-1] == y[WIDTH-1]) begin
            v_s = (s[WIDTH-1] != x[WIDTH-1]);
        end else begin
            v_s = 1'b0;
        end
    end

    // Pack the status bits into the {N,Z,C,V} vector.
    always_comb begin
        flags = pack_flags(n_s, z_s, c_out, v_s);
    end

endmodule

// File: rtl/add_result_stage.sv
// Registered output stage behind the 32-bit adder. Captures the sum with its
// N/Z/C/V flags and hands it to writeback over valid/ready. A main register
// drives the outputs; a skid register absorbs one extra result when the
// consumer stalls, so in_ready can be registered without losing throughput.
// Optional build macro: ALU_STICKY_FLAGS_EN adds an accumulated sticky flag
// register, ORed with the flags of each emitted result.
module add_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] s,
    input  logic             c_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output flags_t           out_flags,
    output flags_t           sticky,
    input  logic             sticky_clr
);

    // Entry shape for this instance's width (matches alu_pkg::entry_t at 32).
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        flags_t           flags;
    } stage_entry_t;

    localparam int ENTRY_W = $bits(stage_entry_t);

    state_t       state_r;
    stage_entry_t main_r;
    stage_entry_t skid_r;
    logic         in_ready_r;
    logic         out_valid_r;

    flags_t       in_flags_s;
    stage_entry_t in_entry_s;
    logic         accept_s;
    logic         emit_s;

    // Flags are computed once, on the way in, and travel with the entry.
    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .x     (x),
        .y     (y),
        .s     (s),
        .c_out (c_out),
        .flags (in_flags_s)
    );

    // Form the incoming entry and the two handshake events.
    always_comb begin
        in_entry_s.sum   = s;
        in_entry_s.flags = in_flags_s;
        accept_s         = in_valid && in_ready_r;
        emit_s           = out_valid_r && out_ready;
    end

    // Occupancy FSM with the main/skid entry registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r     <= EMPTY;
            main_r      <= {ENTRY_W{1'b0}};
            skid_r      <= {ENTRY_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        main_r      <= in_entry_s;
                        state_r     <= ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && emit_s) begin
                        // Head leaves as the new result replaces it.
                        main_r  <= in_entry_s;
                        state_r <= ONE;
                    end else if (accept_s) begin
                        // Consumer stalled: park the new result behind the head.
                        skid_r     <= in_entry_s;
                        state_r    <= TWO;
                        in_ready_r <= 1'b0;
                    end else if (emit_s) begin
                        // main_r keeps its value; it is don't-care until the next load.
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= ONE;
                    end
                end
                TWO: begin
                    if (emit_s) begin
                        main_r     <= skid_r;
                        state_r    <= ONE;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r <= TWO;
                    end
                end
                default: begin
                    // Unreachable encoding: return to a clean empty stage.
                    state_r     <= EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        in_ready  = in_ready_r;
        out_valid = out_valid_r;
        out_s     = main_r.sum;
        out_flags = main_r.flags;
    end

`ifdef ALU_STICKY_FLAGS_EN
    flags_t sticky_r;

    // Accumulate flags of every emitted result; an explicit clear wins over a same-cycle emit.
    always_ff @(posedge clk) begin
        if (clr) begin
            sticky_r <= 4'b0000;
        end else if (sticky_clr) begin
            sticky_r <= 4'b0000;
        end else if (emit_s) begin
            sticky_r <= sticky_r | main_r.flags;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    // Present the accumulated flags.
    always_comb begin
        sticky = sticky_r;
    end
`else
    logic unused_sticky_clr_s;

    // Sticky flags are not built in this configuration; the clear input is ignored.
    always_comb begin
        sticky              = 4'b0000;
        unused_sticky_clr_s = sticky_clr;
    end
`endif

endmodule
